register_file_32: RTL
=====================

# register_file_32

32-entry general-purpose register file with a reservation scoreboard. It sits directly upstream of the 32:1 read multiplexers in the datapath. It holds architectural register state, accepts one write per cycle from writeback, and tracks a busy bit per register so that issue logic can stall on pending producers. Each of the two read ports selects one of the 32 entries through a 5-bit address, with write-through bypass.

## Interface
Parameters:
- WIDTH, 32, data width of each register and of all data ports.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous and active-high.
- we  input  1  write enable from writeback.
- waddr  input  5  write address.
- wdata  input  WIDTH  write data.
- ra1  input  5  read address, port 1.
- ra2  input  5  read address, port 2.
- rd1  output  WIDTH  read data, port 1 (combinational).
- rd2  output  WIDTH  read data, port 2 (combinational).
- rsv_en  input  1  reserve request from issue: mark rsv_addr busy.
- rsv_addr  input  5  register being reserved.
- busy1  output  1  pending-write flag for ra1 (combinational).
- busy2  output  1  pending-write flag for ra2 (combinational).

## Operation
- State:
  - regs[1..31], each WIDTH bits.
  - busy[1..31], each 1 bit.
  - Entry 0 is constant: reads as 0, never busy, writes and reserves to it are ignored.
- Write: the regs[waddr] <= wdata update and the busy[waddr] <= 0 clear both happen on the edge when we=1 and waddr!=0.
- Reserve: busy[rsv_addr] <= 1 on the edge when rsv_en=1 and rsv_addr!=0.
- Same edge, write and reserve to the same nonzero address: data is written, and busy ends at 1. The reserve wins because it represents a newer producer.
- Same edge, write and reserve to different addresses: both take effect independently.
- Read, port n:
  - rdn = 0 if ran==0.
  - Otherwise rdn = wdata if we=1 and waddr==ran (write-through bypass).
  - Otherwise rdn = regs[ran].
- Busy, port n:
  - busyn = 0 if ran==0.
  - Otherwise busyn = 0 if we=1 and waddr==ran (the write in progress satisfies the dependency).
  - Otherwise busyn = busy[ran].
  - A reserve in the current cycle is not forwarded to busyn; it becomes visible from the next cycle.
- Both read ports are fully independent and may address the same register.
- Reading an address that is being written returns the new value, never the stale one.

## Timing
- Reset: on a rising edge with rst=1, all regs clear to 0 and all busy bits clear to 0. rst overrides we and rsv_en on that edge.
- Outputs after reset: rd1=rd2=0 and busy1=busy2=0 for any address, unless a bypass is active in the current cycle.
- Write latency: wdata is visible on rdn in the same cycle through the bypass, and from regs starting the cycle after the edge.
- Reserve latency: busyn goes to 1 the cycle after the rsv_en edge.
- Clear latency: busyn goes to 0 in the cycle the matching write is presented (bypass), and stays 0 afterwards unless reserved again.
- Reset asserted mid-operation, with pending reservations: all busy bits are lost; issue logic is flushed concurrently.
- There is no back-pressure and no handshake. One write and one reserve are accepted every cycle.
- Combinational paths:
  - ra/waddr/we/wdata to rd is a mux path only.
  - There is no combinational path from rsv_en or rsv_addr to any output.

## Test plan
- Reset then read: rst=1 for 1 cycle, then sweep ra1 and ra2 over 0..31 -> rd=0 and busy=0 for every address.
- Write/read-back: write regs[k]=k+100 for k=1..31, then read all with ra1=k and ra2=31-k. Required responses:
  - rd1=k+100.
  - rd2=131-k, except rd2=0 when ra2=0.
- Entry 0 and bypass:
  - we=1, waddr=0, wdata=0xDEADBEEF -> rd1 with ra1=0 stays 0.
  - we=1, waddr=5, wdata=0x55 with ra1=5 in the same cycle -> rd1=0x55 in that cycle, while regs[5] still holds the old value.
- Scoreboard:
  - rsv_en on address 7 -> busy1 (ra1=7) is 0 in that cycle and 1 on the next cycle.
  - Write to 7 -> busy1=0 in the write cycle and afterwards.
- Simultaneous write and reserve to 9 -> regs[9] is updated and busy stays 1 afterwards. Write to 9 with reserve to 10 -> busy[9]=0 and busy[10]=1.
- Reset mid-operation: reserve 3 and 4, write regs[3]=0x33, then assert rst -> the next cycle shows rd=0 and busy=0 for 3 and 4.

Source files
------------

// File: rtl/register_file_32.sv
// 32-entry register file with per-register busy scoreboard.
// Entry 0 is hardwired zero; reads bypass the in-flight writeback.
module register_file_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             rsv_en,
    input  logic [4:0]       rsv_addr,
    output logic             busy1,
    output logic             busy2
);

    logic [WIDTH-1:0] r_regs [32];
    logic [31:0]      r_busy;

    logic w_wr_valid;
    logic w_rsv_valid;
    logic w_byp1;
    logic w_byp2;

    assign w_wr_valid  = we && (waddr != 5'd0);
    assign w_rsv_valid = rsv_en && (rsv_addr != 5'd0);
    assign w_byp1      = w_wr_valid && (waddr == ra1);
    assign w_byp2      = w_wr_valid && (waddr == ra2);

    // Reserve is applied after the write clear so a same-address reserve wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i[4:0]] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_valid) begin
                r_regs[waddr] <= wdata;
                r_busy[waddr] <= 1'b0;
            end
            if (w_rsv_valid) begin
                r_busy[rsv_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd1   = '0;
        busy1 = 1'b0;
        if (ra1 != 5'd0) begin
            if (w_byp1) begin
                rd1 = wdata;
            end else begin
                rd1   = r_regs[ra1];
                busy1 = r_busy[ra1];
            end
        end
    end

    always_comb begin
        rd2   = '0;
        busy2 = 1'b0;
        if (ra2 != 5'd0) begin
            if (w_byp2) begin
                rd2 = wdata;
            end else begin
                rd2   = r_regs[ra2];
                busy2 = r_busy[ra2];
            end
        end
    end

endmodule
